// File: rtl/filter_pkg.sv
// Shared types and helpers for the rank-order (median/min/max) window filter.
// Latency: none (package only).
// Backpressure: not applicable.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to index 'value' distinct items (elaboration-time only).
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                bits++;
                rem = rem >> 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/filter_cmp_swap.sv
// Compare-exchange cell: routes the smaller operand to lo and the larger to hi.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to use the result.
module filter_cmp_swap #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    // Strict compare: equal operands pass straight through, unswapped.
    always_comb begin
        if (a > b) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

// File: rtl/filter_rank_seq.sv
// Rank-order selector over a WIN x WIN window using odd-even transposition sort.
// Latency: out_valid rises N cycles after the input handshake (one pass per cycle).
// Backpressure: holds the result until out_ready; in_ready low while busy, no queuing.
module filter_rank_seq
    import filter_pkg::*;
#(
    parameter  int WIN    = 5,
    parameter  int DATA_W = 8,
    localparam int N      = WIN * WIN,
    localparam int RW     = clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   in_matrix,
    input  logic [RW-1:0]         in_rank,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  busy
);

    // One spare bit so the pass counter can reach N without wrapping.
    localparam int PC_W = RW + 1;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   arr     [N];
    logic [DATA_W-1:0]   arr_nxt [N];
    logic [DATA_W-1:0]   cell_lo [N-1];
    logic [DATA_W-1:0]   cell_hi [N-1];
    logic [RW-1:0]       rank;
    logic [PC_W-1:0]     pc;
    logic                load;
    logic                sort_en;

    // One compare-exchange cell per adjacent pair; the pass parity picks which ones apply.
    for (genvar k = 0; k < N - 1; k++) begin : g_cell
        filter_cmp_swap #(
            .DATA_W (DATA_W)
        ) u_cell (
            .a  (arr[k]),
            .b  (arr[k+1]),
            .lo (cell_lo[k]),
            .hi (cell_hi[k])
        );
    end

    // Apply the cells whose pair parity matches the current pass; pairs in a pass are disjoint.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            arr_nxt[i] = arr[i];
        end
        for (int k = 0; k < N - 1; k++) begin
            if (k[0] == pc[0]) begin
                arr_nxt[k]   = cell_lo[k];
                arr_nxt[k+1] = cell_hi[k];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sort_en   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = SORT;
                end
            end
            SORT: begin
                busy    = 1'b1;
                sort_en = 1'b1;
                if (pc == PC_W'(N - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working array, clamped rank and pass counter: load on accept, one pass per SORT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= '0;
            rank <= '0;
            for (int i = 0; i < N; i++) begin
                arr[i] <= '0;
            end
        end else if (load) begin
            pc   <= '0;
            rank <= (in_rank >= RW'(N)) ? RW'(N - 1) : in_rank;
            for (int i = 0; i < N; i++) begin
                arr[i] <= in_matrix[i*DATA_W +: DATA_W];
            end
        end else if (sort_en) begin
            pc <= pc + PC_W'(1);
            for (int i = 0; i < N; i++) begin
                arr[i] <= arr_nxt[i];
            end
        end
    end

    // Result is forced to zero outside DONE so stale sort data never leaks out.
    assign out_data = out_valid ? arr[rank] : '0;

endmodule

// File: doc/filter_rank_seq.md
FILTER_RANK_SEQ -- requirements
Module: filter_rank_seq

Interface
REQ-001 Parameter WIN, default 5: window edge length; SHALL be odd and >= 3.
REQ-002 Parameter DATA_W, default 8: pixel width in bits.
REQ-003 Derived constants N = WIN*WIN (window element count) and RW = clog2(N) (rank index width) SHALL be localparams, not overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 in_valid  input  1  window offered.
REQ-007 in_ready  output  1  block can accept a window.
REQ-008 in_matrix  input  N*DATA_W  window; element i = in_matrix[i*DATA_W +: DATA_W], row-major, row = i/WIN, col = i%WIN.
REQ-009 in_rank  input  RW  rank to select (0 = minimum, (N-1)/2 = median, N-1 = maximum); sampled with the window.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_data  output  DATA_W  selected-rank element.
REQ-013 busy  output  1  high in SORT or DONE.

Function
REQ-014 The FSM SHALL have three states: IDLE, SORT and DONE.
REQ-015 IDLE: in_ready = 1; on in_valid & in_ready, the block SHALL capture all N elements into a working array and capture the rank, clamped to N-1 if in_rank >= N; it SHALL clear pass counter pc and go to SORT.
REQ-016 SORT: in_ready = 0; one odd-even transposition pass per cycle; pass pc even compares pairs (0,1),(2,3),...; pass pc odd compares pairs (1,2),(3,4),...; if a[k] > a[k+1] (unsigned), the pair SHALL swap; pc increments.
REQ-017 After the pass with pc = N-1, the FSM SHALL go to DONE; SORT therefore occupies exactly N cycles.
REQ-018 DONE: out_valid = 1; out_data = a[rank]; out_data SHALL hold stable while out_valid & !out_ready.
REQ-019 DONE with out_ready = 1 SHALL go to IDLE; out_valid SHALL be 0 on the next cycle.
REQ-020 Latency: with the input handshake at edge E, out_valid SHALL rise after edge E+N; minimum initiation interval is N+2 cycles.
REQ-021 in_valid during SORT or DONE SHALL be ignored; the block does not queue windows, and upstream SHALL hold the window until in_ready.
REQ-022 Equal elements SHALL not swap; the result for duplicates is the duplicated value.
REQ-023 pc SHALL be RW+1 bits wide, or wider, and SHALL never wrap within a SORT.
REQ-024 out_data SHALL be 0 whenever out_valid = 0.

Reset
REQ-025 When rst_n is low, the block SHALL be in state IDLE with in_ready = 1, out_valid = 0, out_data = 0, busy = 0, pc = 0, rank = 0 and the working array all zeros.
REQ-026 Reset asserted in SORT or DONE SHALL abort the operation with no result emitted; the first cycle after release behaves as IDLE.

Structure
REQ-027 A shared package filter_pkg SHALL hold the state enum (IDLE/SORT/DONE) and a clog2 constant function.
REQ-028 The compare-exchange cell SHALL be the sub-module filter_cmp_swap (DATA_W parameter; inputs a, b; outputs lo, hi), instantiated N-1 times with per-pass enable.
REQ-029 No multiplier or divider SHALL be inferred; index math is constant at elaboration.

Verification
REQ-030 WIN=5, elements 24..0 descending, in_rank=12 -> out_data=12, out_valid rises 25 cycles after accept.
REQ-031 WIN=5, all elements 0x7F, in_rank=0 and in_rank=24 -> out_data=0x7F both.
REQ-032 WIN=5, random window, in_rank=0 / 24 / 31 -> min / max / max (clamp).
REQ-033 Result ready, out_ready low 10 cycles -> out_valid and out_data stable, in_ready=0; out_ready high -> IDLE next cycle.
REQ-034 rst_n low at SORT cycle 7 -> all outputs at reset values immediately, no out_valid after release; next window processed correctly.
REQ-035 WIN=3, DATA_W=12, elements {4095,0,7,7,3,9,1,2,8}, in_rank=4 -> out_data=7 after 9 SORT cycles.
